ifu_npc: RTL and testbench

- Fetch stage plus next-PC selection plus IF/ID pipeline register for the 5-stage MIPS core.
- Consumes the ID-stage branch comparator `flag` together with decoder control and the forwarded rs value.
- Drives the instruction-memory address and presents the fetched instruction and PC to ID.
- MIPS delay-slot semantics: the instruction after a branch or jump always executes; there is no flush path.

---
 rtl/ifu_npc_pkg.sv | 13 +
 rtl/ifu_npc_if.sv | 31 +++
 rtl/ifu_npc_npc_sel.sv | 42 ++++
 rtl/ifu_npc.sv | 51 +++++
 tb/tb_ifu_npc.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/ifu_npc_pkg.sv
// ifu_npc shared constants: next-PC select encodings and fetch defaults.
// Imported by the fetch stage, its next-PC mux and the fetch interface.
package ifu_npc_pkg;

    localparam logic [2:0] NPC_PC4    = 3'd0;
    localparam logic [2:0] NPC_BRANCH = 3'd1;
    localparam logic [2:0] NPC_J      = 3'd2;
    localparam logic [2:0] NPC_JR     = 3'd3;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam int          PC_STEP_DEF  = 4;

endpackage

// File: rtl/ifu_npc_if.sv
// Fetch/decode bundle: imem fetch bus, ID-stage redirect inputs
// and the IF/ID register outputs.
interface ifu_npc_if;
    import ifu_npc_pkg::*;

    logic        stall;
    logic [31:0] F_instr;
    logic [2:0]  NPCOp;
    logic        flag;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] gpr_rs;
    logic [31:0] F_pc;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic [31:0] D_pc8;
    logic [31:0] npc;

    modport master (
        input  stall, F_instr, NPCOp, flag,
        input  imm16, imm26, gpr_rs,
        output F_pc, D_instr, D_pc, D_pc8, npc
    );

    modport slave (
        output stall, F_instr, NPCOp, flag,
        output imm16, imm26, gpr_rs,
        input  F_pc, D_instr, D_pc, D_pc8, npc
    );

endinterface

// File: rtl/ifu_npc_npc_sel.sv
// Combinational next-PC mux; branch/jump targets are relative to the
// delay slot, which is always fetched before the redirect lands.
module npc_sel
    import ifu_npc_pkg::*;
#(
    parameter int PC_STEP = PC_STEP_DEF
) (
    input  logic [31:0] F_pc,
    input  logic [31:0] D_pc,
    input  logic [2:0]  NPCOp,
    input  logic        flag,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] gpr_rs,
    output logic [31:0] npc
);

    logic [31:0] seq_pc;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic        br_taken;
    logic        is_j;
    logic        is_jr;

    assign seq_pc   = F_pc + 32'(PC_STEP);
    assign br_tgt   = D_pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign j_tgt    = {D_pc[31:28], imm26, 2'b00};
    assign br_taken = (NPCOp == NPC_BRANCH) && flag;
    assign is_j     = (NPCOp == NPC_J);
    assign is_jr    = (NPCOp == NPC_JR);

    always_comb begin
        npc = seq_pc;
        unique case (1'b1)
            br_taken: npc = br_tgt;
            is_j:     npc = j_tgt;
            is_jr:    npc = gpr_rs;
            default:  npc = seq_pc;
        endcase
    end

endmodule

// File: rtl/ifu_npc.sv
// Fetch stage: PC register, next-PC selection and IF/ID register.
// No flush path; the delay slot always advances into ID.
module ifu_npc
    import ifu_npc_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter int          PC_STEP  = PC_STEP_DEF
) (
    input  logic      clk,
    input  logic      reset,
    ifu_npc_if.master bus
);

    logic [31:0] f_pc;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] npc;

    npc_sel #(
        .PC_STEP (PC_STEP)
    ) u_npc_sel (
        .F_pc   (f_pc),
        .D_pc   (d_pc),
        .NPCOp  (bus.NPCOp),
        .flag   (bus.flag),
        .imm16  (bus.imm16),
        .imm26  (bus.imm26),
        .gpr_rs (bus.gpr_rs),
        .npc    (npc)
    );

    // A stall holds D_instr, so a pending redirect is taken only once.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc    <= PC_RESET;
            d_instr <= 32'd0;
            d_pc    <= PC_RESET;
        end else if (!bus.stall) begin
            f_pc    <= npc;
            d_instr <= bus.F_instr;
            d_pc    <= f_pc;
        end
    end

    assign bus.F_pc    = f_pc;
    assign bus.D_instr = d_instr;
    assign bus.D_pc    = d_pc;
    assign bus.D_pc8   = d_pc + 32'd8;
    assign bus.npc     = npc;

endmodule

// File: tb/tb_ifu_npc.sv
// Directed bench for ifu_npc: expected register state is queued at
// drive time and checked one edge later.
module tb_ifu_npc;
    import ifu_npc_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] dpc;
        logic [31:0] di;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_fail;
    exp_t exp_q[$];

    ifu_npc_if bus ();

    ifu_npc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] epc,
                        input logic [31:0] edpc, input logic [31:0] edi);
        exp_t e;
        exp_q.push_back('{tag, epc, edpc, edi});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.tag, ".F_pc"}, bus.F_pc, e.pc);
        chk({e.tag, ".D_pc"}, bus.D_pc, e.dpc);
        chk({e.tag, ".D_instr"}, bus.D_instr, e.di);
        chk({e.tag, ".D_pc8"}, bus.D_pc8, e.dpc + 32'd8);
    endtask

    task automatic drive(input logic st, input logic [2:0] op,
                         input logic fl, input logic [15:0] i16,
                         input logic [25:0] i26, input logic [31:0] rs,
                         input logic [31:0] ins);
        bus.stall   = st;
        bus.NPCOp   = op;
        bus.flag    = fl;
        bus.imm16   = i16;
        bus.imm26   = i26;
        bus.gpr_rs  = rs;
        bus.F_instr = ins;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec  = 0;
        n_fail = 0;
        reset  = 1'b1;
        drive(0, NPC_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h2408_0001);

        step("rst0", 32'h3000, 32'h3000, 32'h0);
        step("rst1", 32'h3000, 32'h3000, 32'h0);
        reset = 1'b0;
        step("first", 32'h3004, 32'h3000, 32'h2408_0001);

        drive(0, NPC_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h1111_0001);
        step("seq", 32'h3008, 32'h3004, 32'h1111_0001);

        drive(0, NPC_BRANCH, 1, 16'hFFFF, 26'h0, 32'h0, 32'h1111_0002);
        #1 chk("br_t.npc", bus.npc, 32'h3004);
        step("br_t", 32'h3004, 32'h3008, 32'h1111_0002);

        drive(0, NPC_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h1111_0003);
        step("pre_nt", 32'h3008, 32'h3004, 32'h1111_0003);
        drive(0, NPC_BRANCH, 0, 16'hFFFF, 26'h0, 32'h0, 32'h1111_0004);
        step("br_nt", 32'h300C, 32'h3008, 32'h1111_0004);

        drive(0, NPC_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h1111_0005);
        step("pre_j0", 32'h3010, 32'h300C, 32'h1111_0005);
        drive(0, NPC_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h1111_0006);
        step("pre_j1", 32'h3014, 32'h3010, 32'h1111_0006);
        drive(0, NPC_J, 0, 16'h0, 26'h000_0C10, 32'h0, 32'h1111_0007);
        step("j", 32'h3040, 32'h3014, 32'h1111_0007);
        drive(0, NPC_JR, 0, 16'h0, 26'h0, 32'h0000_3101, 32'h1111_0008);
        step("jr", 32'h3101, 32'h3040, 32'h1111_0008);

        reset = 1'b1;
        drive(0, NPC_PC4, 0, 16'h0, 26'h0, 32'h0, 32'h0);
        step("rst2", 32'h3000, 32'h3000, 32'h0);
        reset = 1'b0;
        drive(0, NPC_PC4, 0, 16'h0, 26'h0, 32'h0, 32'hAAAA_0001);
        step("pre_st", 32'h3004, 32'h3000, 32'hAAAA_0001);

        drive(1, NPC_BRANCH, 1, 16'h0004, 26'h0, 32'h0, 32'hBBBB_0002);
        step("stall0", 32'h3004, 32'h3000, 32'hAAAA_0001);
        step("stall1", 32'h3004, 32'h3000, 32'hAAAA_0001);
        step("stall2", 32'h3004, 32'h3000, 32'hAAAA_0001);
        bus.stall = 1'b0;
        step("st_rel", 32'h3014, 32'h3004, 32'hBBBB_0002);
        drive(0, NPC_PC4, 0, 16'h0, 26'h0, 32'h0, 32'hCCCC_0003);
        step("st_post", 32'h3018, 32'h3014, 32'hCCCC_0003);

        reset = 1'b1;
        drive(1, NPC_BRANCH, 1, 16'h0004, 26'h0, 32'h0, 32'hDDDD_0004);
        step("rst_st", 32'h3000, 32'h3000, 32'h0);
        reset = 1'b0;

        drive(0, NPC_JR, 0, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'hEEEE_0005);
        step("wrap_jr", 32'hFFFF_FFFC, 32'h3000, 32'hEEEE_0005);
        drive(0, NPC_PC4, 0, 16'h0, 26'h0, 32'h0, 32'hEEEE_0006);
        step("wrap_pc4", 32'h0000_0000, 32'hFFFF_FFFC, 32'hEEEE_0006);
        chk("wrap_pc8", bus.D_pc8, 32'h0000_0004);

        drive(0, NPC_3_UNUSED(), 0, 16'h0, 26'h3FF_FFFF, 32'h1234_5678,
              32'hEEEE_0007);
        step("op_other", 32'h0000_0004, 32'h0000_0000, 32'hEEEE_0007);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    function automatic logic [2:0] NPC_3_UNUSED();
        return 3'd5;
    endfunction

endmodule
